// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sharing sequencer: op codes,
// sequencer state encoding and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter. Grant is one-hot and always a subset of
// valid; ties go to the port that was not granted last, or always to port 0
// when FIXED_PRIO is set.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Pick a single port from the valid vector.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (FIXED_PRIO || last_grant) grant = 2'b01;
        else                          grant = 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// address/branch unit (port 1). One operation is in flight at a time:
// IDLE accepts, EXEC lets the ALU settle on registered operands, RESP holds
// the captured result until the owning port takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters keep operands stable while valid is high and not yet
// accepted and may withdraw valid before acceptance. The response is held
// stable while rsp_valid is high and rsp_ready is low; rsp_ready never
// feeds back combinationally into any output.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_ra,
  input  logic [WIDTH-1:0] req0_rb,
  input  logic [3:0]       req0_sel,
  input  logic [WIDTH-1:0] req1_ra,
  input  logic [WIDTH-1:0] req1_rb,
  input  logic [3:0]       req1_sel,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_ra,
  output logic [WIDTH-1:0] alu_rb,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic [1:0]       dbg_state
);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]       gnt;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .valid      (req_valid),
    .last_grant (last_q),
    .grant      (gnt)
  );

  // Next-state, operand capture and handshake outputs.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    sel_d      = sel_q;
    rsp_data_d = rsp_data_q;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    case (state_q)
      IDLE: begin
        // Hold ready low while reset is applied.
        req_ready = rst ? 2'b00 : gnt;
        if ((req_valid & gnt) != 2'b00) begin
          owner_d = gnt[1];
          ra_d    = gnt[1] ? req1_ra  : req0_ra;
          rb_d    = gnt[1] ? req1_rb  : req0_rb;
          sel_d   = gnt[1] ? req1_sel : req0_sel;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_out;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        // Only the owner's ready matters; the other port's is ignored.
        if (rsp_ready[owner_q]) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      ra_q       <= '0;
      rb_q       <= '0;
      sel_q      <= ALU_ADD;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      sel_q      <= sel_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign alu_ra    = ra_q;
  assign alu_rb    = rb_q;
  assign alu_sel   = sel_q;
  assign rsp_data  = rsp_data_q;
  assign dbg_state = state_q;

endmodule
